// File: rtl/bar_source_if.sv
// bar_if -- simple valid/ready word channel.
//   data  : 32-bit payload, driven by the producer
//   valid : producer has a word on data
//   ready : consumer accepts the word on an edge where valid is also high
interface bar_if;
    logic [31:0] data;
    logic        valid;
    logic        ready;

    modport producer (output data, output valid, input ready);
    modport consumer (input data, input valid, output ready);
endinterface

// File: rtl/bar_source.sv
// bar_source -- circular FIFO that feeds a bar_if producer port.
//
// Ports:
//   clk_i       : clock, all state on rising edge
//   rst_ni      : asynchronous active-low reset
//   wr_data_i   : word to enqueue
//   wr_en_i     : enqueue request (dropped when full)
//   full_o      : buffer holds DEPTH words
//   level_o     : current occupancy, 0..DEPTH
//   overflow_o  : sticky, set once a write has been dropped
//   sent_cnt_o  : completed transfers on x, wraps at 2^16
//   x           : bar_if producer end (drives data/valid, reads ready)
//
// x.valid and x.data are both registered; the head word for the next cycle
// is worked out before the edge so valid never waits a cycle on the memory.
module bar_source #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [31:0]              wr_data_i,
    input  logic                     wr_en_i,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     overflow_o,
    output logic [15:0]              sent_cnt_o,
    bar_if.producer                  x
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [31:0]    mem_q [DEPTH];
    logic [PW-1:0]  rptr_q, rptr_d;
    logic [PW-1:0]  wptr_q, wptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           valid_q, valid_d;
    logic [31:0]    data_q, data_d;
    logic           ovf_q, ovf_d;
    logic [15:0]    sent_q, sent_d;

    logic           full;
    logic           wr_acc;
    logic           xfer;
    logic [31:0]    head_d;

    always_comb begin
        full    = (level_q == DEPTH_L);
        // Full is judged on the current level, so a pop on the same edge
        // does not make room for a write.
        wr_acc  = wr_en_i & ~full;
        // valid_q mirrors (level_q != 0), so it is the only pop qualifier.
        xfer    = valid_q & x.ready;

        rptr_d  = xfer   ? rptr_q + PW'(1) : rptr_q;
        wptr_d  = wr_acc ? wptr_q + PW'(1) : wptr_q;

        level_d = level_q;
        case ({wr_acc, xfer})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // The slot at the new read pointer is being written this very edge
        // only when the buffer ends up holding just the incoming word
        // (empty + write, or level 1 + write + pop); bypass memory then.
        if (wr_acc && (wptr_q == rptr_d)) head_d = wr_data_i;
        else                              head_d = mem_q[rptr_d];

        valid_d = (level_d != '0);
        data_d  = valid_d ? head_d : '0;
        ovf_d   = ovf_q | (wr_en_i & full);
        sent_d  = xfer ? sent_q + 16'd1 : sent_q;
    end

    // Storage has no reset; its contents are meaningless while level is 0.
    always_ff @(posedge clk_i) begin
        if (wr_acc) mem_q[wptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
            sent_q  <= '0;
        end else begin
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            level_q <= level_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
            sent_q  <= sent_d;
        end
    end

    assign x.valid    = valid_q;
    assign x.data     = data_q;
    assign full_o     = full;
    assign level_o    = level_q;
    assign overflow_o = ovf_q;
    assign sent_cnt_o = sent_q;

endmodule

// File: tb/tb_bar_source.sv
module tb_bar_source;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] wr_data_i;
    logic        wr_en_i;
    logic        full_o;
    logic [2:0]  level_o;
    logic        overflow_o;
    logic [15:0] sent_cnt_o;

    bar_if bus ();

    bar_source #(.DEPTH(DEPTH)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .wr_data_i  (wr_data_i),
        .wr_en_i    (wr_en_i),
        .full_o     (full_o),
        .level_o    (level_o),
        .overflow_o (overflow_o),
        .sent_cnt_o (sent_cnt_o),
        .x          (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: the buffer is just a queue of words.
    logic [31:0] mq[$];
    int          msent = 0;
    bit          movf  = 0;
    logic [31:0] seen[$];

    typedef struct {
        logic        wr;
        logic [31:0] d;
        logic        rdy;
        logic        ev;
        logic [31:0] ed;
        int          el;
        logic        ef;
        logic        eo;
        int          es;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_edge(input logic w, input logic [31:0] d, input logic r);
        bit pop, push;
        pop  = (mq.size() != 0) && r;
        push = w && (mq.size() < DEPTH);
        if (w && !push) movf = 1;
        if (pop) begin
            void'(mq.pop_front());
            msent = (msent + 1) & 16'hFFFF;
        end
        if (push) mq.push_back(d);
    endfunction

    function automatic void model_reset();
        mq.delete();
        msent = 0;
        movf  = 0;
    endfunction

    task automatic cmp_model(input string tag);
        chk({tag, ".valid"}, 32'(bus.valid), 32'(mq.size() != 0));
        if (mq.size() != 0) chk({tag, ".data"}, bus.data, mq[0]);
        chk({tag, ".level"}, 32'(level_o), 32'(mq.size()));
        chk({tag, ".full"}, 32'(full_o), 32'(mq.size() == DEPTH));
        chk({tag, ".ovf"}, 32'(overflow_o), 32'(movf));
        chk({tag, ".sent"}, 32'(sent_cnt_o), 32'(msent));
    endtask

    task automatic step(input string tag, input logic w, input logic [31:0] d, input logic r);
        wr_en_i   = w;
        wr_data_i = d;
        bus.ready = r;
        if (bus.valid && r) seen.push_back(bus.data);
        @(posedge clk);
        model_edge(w, d, r);
        #1;
        cmp_model(tag);
    endtask

    function automatic void add(input logic w, input logic [31:0] d, input logic r,
                                input logic ev, input logic [31:0] ed, input int el,
                                input logic ef, input logic eo, input int es);
        vec_t v;
        v.wr = w; v.d = d; v.rdy = r; v.ev = ev; v.ed = ed;
        v.el = el; v.ef = ef; v.eo = eo; v.es = es;
        tbl.push_back(v);
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int sent0;

        // basic
        add(1, 32'hA5A5_0001, 1, 1, 32'hA5A5_0001, 1, 0, 0, 0);
        add(0, 32'h0,         1, 0, 32'h0,         0, 0, 0, 1);
        // backpressure: 10 cycles with 0x11 at the head
        add(1, 32'h11, 0, 1, 32'h11, 1, 0, 0, 1);
        add(1, 32'h22, 0, 1, 32'h11, 2, 0, 0, 1);
        for (int i = 0; i < 8; i++) add(0, 32'h0, 0, 1, 32'h11, 2, 0, 0, 1);
        add(0, 32'h0, 1, 1, 32'h22, 1, 0, 0, 2);
        add(0, 32'h0, 1, 0, 32'h0,  0, 0, 0, 3);
        // full / overflow
        add(1, 32'h101, 0, 1, 32'h101, 1, 0, 0, 3);
        add(1, 32'h102, 0, 1, 32'h101, 2, 0, 0, 3);
        add(1, 32'h103, 0, 1, 32'h101, 3, 0, 0, 3);
        add(1, 32'h104, 0, 1, 32'h101, 4, 1, 0, 3);
        add(1, 32'h105, 0, 1, 32'h101, 4, 1, 1, 3);
        // push + pop while full: head leaves, write dropped
        add(1, 32'h106, 1, 1, 32'h102, 3, 0, 1, 4);
        add(0, 32'h0,   1, 1, 32'h103, 2, 0, 1, 5);
        add(0, 32'h0,   1, 1, 32'h104, 1, 0, 1, 6);
        add(0, 32'h0,   1, 0, 32'h0,   0, 0, 1, 7);

        rst_n = 1'b0;
        wr_en_i = 1'b0;
        wr_data_i = '0;
        bus.ready = 1'b0;
        #12;
        chk("rst.valid", 32'(bus.valid), 32'd0);
        chk("rst.data",  bus.data, 32'd0);
        chk("rst.level", 32'(level_o), 32'd0);
        chk("rst.full",  32'(full_o), 32'd0);
        chk("rst.ovf",   32'(overflow_o), 32'd0);
        chk("rst.sent",  32'(sent_cnt_o), 32'd0);
        rst_n = 1'b1;
        model_reset();

        // Table vectors; first one writes on the first edge after release.
        foreach (tbl[i]) begin
            wr_en_i   = tbl[i].wr;
            wr_data_i = tbl[i].d;
            bus.ready = tbl[i].rdy;
            @(posedge clk);
            model_edge(tbl[i].wr, tbl[i].d, tbl[i].rdy);
            #1;
            chk($sformatf("vec%0d.valid", i), 32'(bus.valid), 32'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("vec%0d.data", i), bus.data, tbl[i].ed);
            chk($sformatf("vec%0d.level", i), 32'(level_o), 32'(tbl[i].el));
            chk($sformatf("vec%0d.full", i), 32'(full_o), 32'(tbl[i].ef));
            chk($sformatf("vec%0d.ovf", i), 32'(overflow_o), 32'(tbl[i].eo));
            chk($sformatf("vec%0d.sent", i), 32'(sent_cnt_o), 32'(tbl[i].es));
        end

        // Streaming with wrap: 20 writes at full rate, then one drain edge.
        base  = int'($urandom);
        sent0 = msent;
        seen.delete();
        for (int i = 0; i < 20; i++) step("stream", 1, 32'(base + i), 1);
        step("stream_tail", 0, 32'h0, 1);
        chk("stream.count", 32'(seen.size()), 32'd20);
        for (int i = 0; i < seen.size(); i++) chk("stream.order", seen[i], 32'(base + i));
        chk("stream.sent", 32'(sent_cnt_o), 32'((sent0 + 20) & 16'hFFFF));

        // Reset between edges with three words buffered.
        step("pre_rst", 1, 32'hC0DE_0001, 0);
        step("pre_rst", 1, 32'hC0DE_0002, 0);
        step("pre_rst", 1, 32'hC0DE_0003, 0);
        chk("pre_rst.level3", 32'(level_o), 32'd3);
        wr_en_i = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(bus.valid), 32'd0);
        chk("arst.level", 32'(level_o), 32'd0);
        chk("arst.sent",  32'(sent_cnt_o), 32'd0);
        chk("arst.ovf",   32'(overflow_o), 32'd0);
        chk("arst.data",  bus.data, 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("post_rst_idle", 0, 32'hDEAD_BEEF, 1);
        step("post_rst_wr", 1, 32'h0000_5A5A, 0);
        chk("post_rst_wr.data", bus.data, 32'h0000_5A5A);

        // Random traffic against the queue model.
        for (int i = 0; i < 600; i++) begin
            logic w, r;
            w = ($urandom_range(0, 3) != 0);
            r = (i % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            step("rand", w, $urandom, r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bar_source.md
BAR_SOURCE -- requirements
Module: bar_source

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of buffer entries; legal values are powers of two, 2..16.
REQ-002 The block SHALL have port clk_i, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port wr_data_i, input, 32 bits: the word to enqueue.
REQ-005 The block SHALL have port wr_en_i, input, 1 bit: enqueue request for wr_data_i.
REQ-006 The block SHALL have port full_o, output, 1 bit: the buffer holds DEPTH words.
REQ-007 The block SHALL have port level_o, output, $clog2(DEPTH)+1 bits: the current occupancy.
REQ-008 The block SHALL have port overflow_o, output, 1 bit: sticky flag, set when a write is dropped.
REQ-009 The block SHALL have port sent_cnt_o, output, 16 bits: count of completed transfers, wrapping.
REQ-010 The block SHALL have port x, a bar interface port: the block drives x.data (32 bits) and x.valid (1 bit) and reads x.ready (1 bit); it is the producer end of that interface.

Function
REQ-011 The buffer SHALL be a circular FIFO with DEPTH entries, a read pointer, a write pointer and an occupancy counter.
REQ-012 A write SHALL be accepted when wr_en_i=1 and full_o=0 on a rising edge; the word is stored at the write pointer, and the write pointer increments modulo DEPTH.
REQ-013 When wr_en_i=1 and full_o=1, the word SHALL be dropped, overflow_o SHALL become 1 on the next cycle, and the buffer state SHALL NOT change.
REQ-014 x.valid SHALL be registered, equal to (level != 0) after each edge; x.data SHALL equal the entry at the read pointer.
REQ-015 A transfer SHALL occur on an edge where x.valid=1 and x.ready=1; the read pointer then increments modulo DEPTH and sent_cnt_o increments modulo 2^16.
REQ-016 While x.valid=1 and x.ready=0, x.valid and x.data SHALL hold stable; the block SHALL never deassert valid or change data before a transfer.
REQ-017 x.valid SHALL NOT depend combinationally on x.ready.
REQ-018 Latency: a word written into an empty buffer at edge N SHALL appear with x.valid=1 after edge N and can transfer at edge N+1.
REQ-019 Simultaneous accepted write and transfer SHALL leave level unchanged and both pointers advanced; with level=1 the new word SHALL be presented after the edge, and x.valid SHALL remain 1.
REQ-020 Full is decided combinationally from the current level: a write while full SHALL be dropped even if a transfer occurs on the same edge.
REQ-021 Pointers SHALL wrap from DEPTH-1 to 0 without bubbles; throughput SHALL be one word per cycle when x.ready is held at 1 and wr_en_i is held at 1.
REQ-022 full_o SHALL equal (level == DEPTH), and level_o SHALL equal level.
REQ-023 overflow_o SHALL remain 1 until reset.

Reset
REQ-024 On rst_ni=0, asynchronously, the block SHALL clear pointers, level, overflow_o and sent_cnt_o, and drive x.valid=0 and x.data=0; buffer contents SHALL be don't-care.
REQ-025 Reset asserted mid-transfer SHALL discard all buffered words; after release, x.valid SHALL stay 0 until a new write.
REQ-026 The first write SHALL be accepted on the first rising edge after rst_ni rises.

Verification
REQ-027 Scenario, basic: write 0xA5A5_0001 with x.ready=1 -> x.valid=1 and x.data=0xA5A5_0001 for one cycle, sent_cnt_o=1, level_o returns to 0.
REQ-028 Scenario, backpressure: hold x.ready=0 and write 0x11, 0x22 -> x.data stays 0x11 with x.valid=1 for 10 cycles, level_o=2; release ready -> 0x11 then 0x22 on consecutive edges.
REQ-029 Scenario, full/overflow: with DEPTH=4 and x.ready=0, write 5 words -> full_o=1, level_o=4, overflow_o=1, and the 5th word never appears; draining yields exactly words 1-4 in order.
REQ-030 Scenario, streaming and wrap: ready=1 and wr_en_i=1 for 20 cycles with an incrementing pattern -> 20 transfers in order, no gaps after the first, pointers wrap 5 times.
REQ-031 Scenario, simultaneous push/pop at full: level_o=4, x.ready=1, wr_en_i=1 -> head transfers, the write is dropped, level_o=3, overflow_o=1.
REQ-032 Scenario, reset mid-operation: level_o=3, assert rst_ni=0 asynchronously between edges -> x.valid=0, level_o=0 and sent_cnt_o=0 immediately, with no stale data after release.
